// File: rtl/priority_code_fifo.sv
// Change-triggered FIFO for a 2-bit priority-encoder code {W,Y}.
// Define PRIORITY_CODE_FIFO_TIMESTAMP_EN to add an 8-bit push timestamp (out_stamp) per entry.
module priority_code_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     W,
  input  logic                     Y,
  input  logic                     req_any,
  output logic [1:0]               out_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef PRIORITY_CODE_FIFO_TIMESTAMP_EN
  ,
  output logic [7:0]               out_stamp
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [1:0]    s_code;
  logic [1:0]    prev_code;
  logic          s_any;
  logic          prev_any;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    code_mem [DEPTH];
  logic          evt;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;

  // Two-stage input history: s_* is the current sample, prev_* the one before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_code    <= 2'b00;
      s_any     <= 1'b0;
      prev_code <= 2'b00;
      prev_any  <= 1'b0;
    end else begin
      s_code    <= {W, Y};
      s_any     <= req_any;
      prev_code <= s_code;
      prev_any  <= s_any;
    end
  end

  assign evt   = s_any && (!prev_any || (s_code != prev_code));
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign pop   = !empty && out_ready;
  assign push  = evt && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      // A new drop in the same cycle as a clear request keeps the flag set.
      if (evt && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)        overflow <= 1'b0;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr; the head is consumed on the same edge.
  always_ff @(posedge clk) begin
    if (push) code_mem[wr_ptr] <= s_code;
  end

  assign out_valid = !empty;
  assign out_code  = empty ? 2'b00 : code_mem[rd_ptr];

`ifdef PRIORITY_CODE_FIFO_TIMESTAMP_EN
  logic [7:0] stamp_ctr;
  logic [7:0] stamp_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_ctr <= 8'd0;
    else        stamp_ctr <= stamp_ctr + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push) stamp_mem[wr_ptr] <= stamp_ctr;
  end

  assign out_stamp = empty ? 8'd0 : stamp_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_priority_code_fifo.sv
// Scoreboard bench for priority_code_fifo: a queue-based reference model predicts entries,
// a negedge monitor compares head, count, valid and overflow against it.
module tb_priority_code_fifo;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w = 1'b0;
  logic          y = 1'b0;
  logic          req_any = 1'b0;
  logic          out_ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [1:0]    out_code;
  logic          out_valid;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef PRIORITY_CODE_FIFO_TIMESTAMP_EN
  logic [7:0]    out_stamp;
`endif

  int check_cnt = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [1:0] code;
    logic [7:0] stamp;
  } entry_t;

  entry_t exp_q[$];
  int         m_count = 0;
  logic       m_ovf = 1'b0;
  logic       m_pend = 1'b0;
  logic [1:0] m_pend_code = 2'b00;
  logic       m_last_any = 1'b0;
  logic [1:0] m_last_code = 2'b00;
  int         m_cyc = 0;

  priority_code_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .W(w),
    .Y(y),
    .req_any(req_any),
    .out_code(out_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
`ifdef PRIORITY_CODE_FIFO_TIMESTAMP_EN
    ,
    .out_stamp(out_stamp)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic apply_stimulus(input logic [1:0] code, input logic any, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    {w, y}    = code;
    req_any   = any;
    out_ready = rdy;
    ovf_clr   = clr;
  endtask

  // Reference model: an event is a new active code versus the previous sample; it enters the FIFO one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_count = 0;
      m_ovf = 1'b0;
      m_pend = 1'b0;
      m_pend_code = 2'b00;
      m_last_any = 1'b0;
      m_last_code = 2'b00;
      m_cyc = 0;
    end else begin
      logic m_pop;
      logic m_drop;
      m_pop  = (m_count > 0) && out_ready;
      m_drop = 1'b0;
      if (m_pend) begin
        if (m_count < DEPTH || m_pop) begin
          exp_q.push_back('{m_pend_code, 8'(m_cyc)});
          m_count++;
        end else begin
          m_drop = 1'b1;
        end
      end
      if (m_pop) m_count--;
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_pend = req_any && (!m_last_any || ({w, y} != m_last_code));
      m_pend_code = {w, y};
      m_last_any = req_any;
      m_last_code = {w, y};
      m_cyc = (m_cyc + 1) % 256;
    end
  end

  // Monitor: compares the presented head against the scoreboard and retires it when accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      check_output("out_valid", int'(out_valid), int'(m_count > 0));
      check_output("count", int'(count), m_count);
      check_output("overflow", int'(overflow), int'(m_ovf));
      check_output("out_code", int'(out_code), (exp_q.size() > 0) ? int'(exp_q[0].code) : 0);
`ifdef PRIORITY_CODE_FIFO_TIMESTAMP_EN
      check_output("out_stamp", int'(out_stamp), (exp_q.size() > 0) ? int'(exp_q[0].stamp) : 0);
`endif
      if (m_count > 0 && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic drain();
    repeat (DEPTH + 4) apply_stimulus(2'b00, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", int'(out_valid), 0);
    check_output("reset_count", int'(count), 0);
    rst_n = 1'b1;

    // Held code produces one entry.
    repeat (12) apply_stimulus(2'b10, 1'b1, 1'b0, 1'b0);
    check_output("held_count", int'(count), 1);
    drain();

    // Fill, overflow on a further change, then clear.
    apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b10, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b11, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0);
    repeat (3) apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0);
    check_output("ovf_set", int'(overflow), 1);
    apply_stimulus(2'b00, 1'b1, 1'b0, 1'b1);
    apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0);
    check_output("ovf_cleared", int'(overflow), 0);
    drain();

    // Full FIFO with push and pop on the same edge.
    apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b10, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b11, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b11, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b11, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b01, 1'b1, 1'b1, 1'b0);
    repeat (6) apply_stimulus(2'b01, 1'b1, 1'b1, 1'b0);
    drain();

    // Six pushes while draining every other cycle, crossing the pointer wrap.
    for (int i = 0; i < 6; i++) apply_stimulus(2'(i % 4), 1'b1, 1'(i % 2), 1'b0);
    for (int i = 0; i < 12; i++) apply_stimulus(2'b01, 1'b1, 1'(i % 2), 1'b0);
    drain();

    // Mid-operation reset with 11 held through release.
    apply_stimulus(2'b00, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b01, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b10, 1'b1, 1'b0, 1'b0);
    apply_stimulus(2'b11, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_valid", int'(out_valid), 0);
    check_output("async_count", int'(count), 0);
    check_output("async_ovf", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) apply_stimulus(2'b11, 1'b1, 1'b0, 1'b0);
    check_output("post_reset_count", int'(count), 1);
    check_output("post_reset_code", int'(out_code), 3);
    drain();

    // Randomized traffic, long enough to wrap the timestamp counter several times.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] code;
      code = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : {w, y};
      apply_stimulus(code, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 4),
                     ($urandom_range(0, 19) == 0));
    end
    drain();
    check_output("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/priority_code_fifo.md
PRIORITY_CODE_FIFO -- requirements
Module: priority_code_fifo

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4, the FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL expose port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL expose port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL expose port W, input, 1, the encoder code MSB from the upstream priority encoder.
REQ-005 The block SHALL expose port Y, input, 1, the encoder code LSB from the upstream priority encoder.
REQ-006 The block SHALL expose port req_any, input, 1, high when any encoder request line is active.
REQ-007 The block SHALL expose port out_code, output, 2, the head-entry code {W,Y}.
REQ-008 The block SHALL expose port out_valid, output, 1, high when the FIFO is non-empty.
REQ-009 The block SHALL expose port out_ready, input, 1, consumer accept.
REQ-010 The block SHALL expose port count, output, $clog2(DEPTH)+1, the current entry count.
REQ-011 The block SHALL expose port overflow, output, 1, the sticky dropped-event flag.
REQ-012 The block SHALL expose port ovf_clr, input, 1, a synchronous clear for overflow.

Function
REQ-013 The block SHALL register W, Y and req_any into sample registers s_code and s_any on every rising edge.
REQ-014 The block SHALL update prev_code and prev_any from s_code and s_any on every edge.
REQ-015 The block SHALL detect an event when s_any==1 AND (prev_any==0 OR s_code!=prev_code).
REQ-016 On an event, the block SHALL push s_code at the next edge, so an input change is visible on out_valid/out_code 2 edges later when the FIFO was empty.
REQ-017 A pop SHALL occur at an edge where out_valid&&out_ready; out_code SHALL then advance to the next entry.
REQ-018 While empty, the block SHALL drive out_valid=0 and out_code=2'b00, and out_ready SHALL be ignored.
REQ-019 On push while full without a pop, the block SHALL drop the entry, leave count at DEPTH and set overflow.
REQ-020 On simultaneous push and pop while full, both SHALL take effect, with count unchanged and overflow not set.
REQ-021 On simultaneous push and pop while empty, only the push SHALL take effect and count SHALL become 1.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH, with no lost or duplicated entries across a wrap.
REQ-023 ovf_clr SHALL clear overflow at the next edge; if a new overflow occurs in the same cycle, set SHALL win.
REQ-024 A steady held input (same code, req_any high) SHALL produce exactly one entry.
REQ-025 A req_any falling edge SHALL produce no entry.

Reset
REQ-026 rst_n low SHALL immediately clear all pointers, count, overflow, s_code, s_any, prev_code and prev_any, drive out_valid=0 and out_code=0, and optionally zero out_stamp.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries.
REQ-028 After rst_n deasserts, the first edge SHALL be treated as normal operation, and a code held high across reset SHALL be captured as a new event.

Configuration
REQ-029 With PRIORITY_CODE_FIFO_TIMESTAMP_EN defined, the block SHALL keep an 8-bit free-running cycle counter, reset to 0 and wrapping 255->0.
REQ-030 With PRIORITY_CODE_FIFO_TIMESTAMP_EN defined, each entry SHALL store the counter value at the push edge alongside the code.
REQ-031 With PRIORITY_CODE_FIFO_TIMESTAMP_EN defined, the block SHALL add output port out_stamp[7:0] carrying the head-entry stamp, 0 when empty.
REQ-032 Without PRIORITY_CODE_FIFO_TIMESTAMP_EN, the counter and out_stamp SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then {W,Y}=10, req_any=1, out_ready=0 -> out_valid=1 and out_code=10 after edge 2; count=1; input held 10 cycles -> count stays 1.
REQ-034 Inputs sequence 00,01,10,11, one per cycle, req_any=1, out_ready=0 -> count=4 and overflow=0; a further change to 00 -> count=4, overflow=1; then ovf_clr pulse -> overflow=0.
REQ-035 FIFO full (00,01,10,11), out_ready=1 plus a new event the same cycle -> count stays 4; pop order 00,01,10,11 then the new code; overflow=0.
REQ-036 Push 6 codes while draining 1 per 2 cycles (pointer wrap at DEPTH=4) -> the output sequence matches the input order exactly with no drops.
REQ-037 rst_n pulled low with 3 entries stored -> out_valid=0, count=0 and overflow=0 asynchronously; W=1,Y=1,req_any=1 held through release -> one entry 11.
REQ-038 With PRIORITY_CODE_FIFO_TIMESTAMP_EN defined, events pushed at counter values 5 and 9 -> out_stamp reads 5 then 9 on pop; counter wraps 255->0.
